// File: rtl/half_subtractor_pkg.sv
// Shared lane arithmetic for the registered half subtractor.
// Holds the one-bit truth function and the borrow popcount.
package half_subtractor_pkg;

    localparam int MAX_WIDTH = 64;
    localparam int MAX_CNT_W = 7;

    typedef struct packed {
        logic d;
        logic bout;
    } lane_result_t;

    function automatic lane_result_t lane_sub(input logic a, input logic bin);
        lane_result_t r;
        r.d    = a ^ bin;
        r.bout = ~a & bin;
        return r;
    endfunction

    // Callers zero-extend narrower vectors to MAX_WIDTH before counting.
    function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
        logic [MAX_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            n = n + MAX_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/half_subtractor_half_sub_cell.sv
// Purely combinational one-bit half subtractor cell.
module half_sub_cell
    import half_subtractor_pkg::*;
(
    input  logic a,
    input  logic bin,
    output logic d,
    output logic bout
);

    lane_result_t res;

    always_comb begin
        res  = lane_sub(a, bin);
        d    = res.d;
        bout = res.bout;
    end

endmodule

// File: rtl/half_subtractor.sv
// Registered, lane-parallel half subtractor with valid flag and borrow count.
// Lanes are independent; results appear one clock after an accepted beat.
module half_subtractor
    import half_subtractor_pkg::*;
#(
    parameter  int WIDTH = 1,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] bin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] bout,
    output logic             out_valid,
    output logic [CNT_W-1:0] bout_count
);

    logic [WIDTH-1:0]     d_next;
    logic [WIDTH-1:0]     bout_next;
    logic [MAX_WIDTH-1:0] bout_ext;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_sub_cell u_cell (
            .a    (a[i]),
            .bin  (bin[i]),
            .d    (d_next[i]),
            .bout (bout_next[i])
        );
    end

    always_comb begin
        bout_ext              = '0;
        bout_ext[WIDTH-1:0]   = bout_next;
    end

    // Data registers load only on accepted beats so idle-cycle inputs never leak through.
    always_ff @(posedge clk) begin
        if (rst) begin
            d          <= '0;
            bout       <= '0;
            bout_count <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d          <= d_next;
                bout       <= bout_next;
                bout_count <= CNT_W'(popcount(bout_ext));
            end
        end
    end

endmodule

// File: tb/tb_half_subtractor.sv
// Scoreboard bench for half_subtractor: a WIDTH=8 instance and a WIDTH=1 instance
// share clock, reset and valid; the narrow one sees lane 0 of the wide inputs.
module tb_half_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a_s;
    logic [7:0] bin_s;

    logic [7:0] d8, bout8;
    logic [3:0] cnt8;
    logic       ov8;
    logic       d1, bout1, cnt1, ov1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] d8;
        logic [7:0] bout8;
        logic [3:0] cnt8;
        logic       ov;
        logic       d1;
        logic       bout1;
        logic       cnt1;
    } exp_t;

    exp_t exp_q[$];
    exp_t model;

    always #5 clk = ~clk;

    half_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a_s), .bin(bin_s), .in_valid(in_valid),
        .d(d8), .bout(bout8), .out_valid(ov8), .bout_count(cnt8)
    );

    half_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a_s[0]), .bin(bin_s[0]), .in_valid(in_valid),
        .d(d1), .bout(bout1), .out_valid(ov1), .bout_count(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, predict the post-edge outputs, then compare after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a_s      = av;
        bin_s    = bv;
        if (r) begin
            model = '{8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        end else begin
            model.ov = v;
            if (v) begin
                for (int i = 0; i < 8; i++) begin
                    model.d8[i]    = (av[i] != bv[i]);
                    model.bout8[i] = (av[i] == 1'b0) && (bv[i] == 1'b1);
                end
                model.cnt8  = 4'($countones(model.bout8));
                model.d1    = model.d8[0];
                model.bout1 = model.bout8[0];
                model.cnt1  = model.bout8[0];
            end
        end
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("d8",    32'(d8),    32'(e.d8));
        check("bout8", 32'(bout8), 32'(e.bout8));
        check("cnt8",  32'(cnt8),  32'(e.cnt8));
        check("ov8",   32'(ov8),   32'(e.ov));
        check("d1",    32'(d1),    32'(e.d1));
        check("bout1", 32'(bout1), 32'(e.bout1));
        check("cnt1",  32'(cnt1),  32'(e.cnt1));
        check("ov1",   32'(ov1),   32'(e.ov));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a_s      = '0;
        bin_s    = '0;
        model    = '{8'h00, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held with a valid beat present: outputs must stay zero.
        step(1'b1, 1'b1, 8'h00, 8'h01);
        step(1'b1, 1'b1, 8'h00, 8'h01);

        // Single-lane truth table, back to back.
        step(1'b0, 1'b1, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h01);
        step(1'b0, 1'b1, 8'h01, 8'h00);
        step(1'b0, 1'b1, 8'h01, 8'h01);

        // Wide patterns.
        step(1'b0, 1'b1, 8'hF0, 8'h3C);
        step(1'b0, 1'b1, 8'h00, 8'hFF);
        // Idle with changed inputs: data must hold.
        step(1'b0, 1'b0, 8'hA5, 8'h5A);
        step(1'b0, 1'b0, 8'hxx, 8'hxx);
        step(1'b0, 1'b1, 8'hFF, 8'h00);

        // Reset collides with a valid beat; that beat is dropped.
        step(1'b0, 1'b1, 8'h00, 8'hFF);
        step(1'b1, 1'b1, 8'h00, 8'h01);
        step(1'b0, 1'b1, 8'h00, 8'h01);
        step(1'b0, 1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
        step(1'b0, 1'b0, 8'h00, 8'h00);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
